// File: rtl/stage_multiplier.sv
// -----------------------------------------------------------------------------
// stage_multiplier
//   Pipelined RV32M multiply unit (MUL, MULH, MULHSU, MULHU) placed beside
//   stage_ex. It has a fixed latency of MUL_LATENCY cycles and can accept one
//   op per cycle. Results are returned in order with their destination
//   register.
//
// Ports
//   clk             clock; all state changes on the rising edge
//   reset           asynchronous, active-high reset
//   valid_i         decode presents a valid instruction
//   opcode_i        instruction opcode [6:0]
//   funct7_i        instruction funct7 [6:0]
//   funct3_i        instruction funct3 [2:0]
//   op1_data_i      rs1 data
//   op2_data_i      rs2 data
//   rd_i            destination register of the incoming op
//   stall_i         freeze the whole pipeline, including the output stage
//   flush_i         kill in-flight and incoming ops (overrides stall_i)
//   chk_rs1_i       decode rs1, compared against in-flight rd values
//   chk_rs2_i       decode rs2, compared against in-flight rd values
//   valid_result_o  result valid
//   mult_result_o   result data (meaningful only while valid_result_o=1)
//   rd_o            destination register of the result
//   busy_o          at least one stage holds a valid op
//   hazard_o        a valid in-flight op with rd!=0 matches chk_rs1_i/chk_rs2_i
// -----------------------------------------------------------------------------
module stage_multiplier #(
    parameter int WD_SIZE     = 32,
    parameter int REG_SIZE    = 5,
    parameter int MUL_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [6:0]          opcode_i,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          funct3_i,
    input  logic [WD_SIZE-1:0]  op1_data_i,
    input  logic [WD_SIZE-1:0]  op2_data_i,
    input  logic [REG_SIZE-1:0] rd_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [REG_SIZE-1:0] chk_rs1_i,
    input  logic [REG_SIZE-1:0] chk_rs2_i,
    output logic                valid_result_o,
    output logic [WD_SIZE-1:0]  mult_result_o,
    output logic [REG_SIZE-1:0] rd_o,
    output logic                busy_o,
    output logic                hazard_o
);

    localparam int         LAST       = MUL_LATENCY - 1;
    localparam int         PW         = 2 * WD_SIZE;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Extend an operand by one bit, as signed or unsigned as the op requires.
    function automatic logic signed [WD_SIZE:0] ext_operand(
        input logic [WD_SIZE-1:0] d,
        input logic               is_signed
    );
        return is_signed ? {d[WD_SIZE-1], d} : {1'b0, d};
    endfunction

    // Pick the low or high word of the product.
    function automatic logic [WD_SIZE-1:0] select_half(
        input logic signed [PW-1:0] p,
        input logic                 hi
    );
        return hi ? p[PW-1:WD_SIZE] : p[WD_SIZE-1:0];
    endfunction

    logic accept;
    logic rs1_signed;
    logic rs2_signed;

    // Stage 0 holds extended operands, later stages hold the selected word.
    logic                       vld_p [MUL_LATENCY];
    logic [REG_SIZE-1:0]        rd_p  [MUL_LATENCY];
    logic signed [WD_SIZE:0]    op1_p0;
    logic signed [WD_SIZE:0]    op2_p0;
    logic                       hi_p0;
    logic [WD_SIZE-1:0]         res_p [1:LAST];
    logic signed [PW-1:0]       prod_p0;

    assign accept = valid_i && (opcode_i == OPC_OP) && (funct7_i == F7_MULDIV) &&
                    !funct3_i[2] && !stall_i && !flush_i;

    // MULH (01) and MULHSU (10) treat rs1 as signed; only MULH treats rs2 as
    // signed. MUL (00) only uses the low word, where signedness is irrelevant.
    assign rs1_signed = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
    assign rs2_signed = (funct3_i[1:0] == 2'b01);

    // Only bits [63:0] of the 66-bit signed product are ever selected, and
    // those are exact under a 64-bit modular multiply of the extended operands.
    assign prod_p0 = PW'(op1_p0) * PW'(op2_p0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                rd_p[i]  <= '0;
            end
            op1_p0 <= '0;
            op2_p0 <= '0;
            hi_p0  <= 1'b0;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                res_p[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else if (!stall_i) begin
            // stage 0: capture extended operands
            vld_p[0] <= accept;
            rd_p[0]  <= rd_i;
            op1_p0   <= ext_operand(op1_data_i, rs1_signed);
            op2_p0   <= ext_operand(op2_data_i, rs2_signed);
            hi_p0    <= (funct3_i[1:0] != 2'b00);
            // stage 1: multiply and select the result word
            vld_p[1] <= vld_p[0];
            rd_p[1]  <= rd_p[0];
            res_p[1] <= select_half(prod_p0, hi_p0);
            // stages 2..LAST: delay line up to the output stage
            for (int i = 2; i < MUL_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                rd_p[i]  <= rd_p[i-1];
                res_p[i] <= res_p[i-1];
            end
        end
    end

    assign valid_result_o = vld_p[LAST];
    assign mult_result_o  = res_p[LAST];
    assign rd_o           = rd_p[LAST];

    always_comb begin
        busy_o   = 1'b0;
        hazard_o = 1'b0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            busy_o = busy_o | vld_p[i];
            if (vld_p[i] && (rd_p[i] != '0) &&
                ((rd_p[i] == chk_rs1_i) || (rd_p[i] == chk_rs2_i))) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule
